mem_rd_sched: RTL and testbench

Round-robin scheduler for the single shared SRAM read port and the free-list free port. Sits between the per-egress-port memory read controllers and the `sram`/`fl` instances. Grants one read per cycle with bounded burst locking so a port can stream a frame's blocks back-to-back. Tags every issued read so the returning data is steered to the port that requested it.

---
 rtl/mem_rd_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_rd_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_sched.sv
`default_nettype none
// ============================================================================
// Module : mem_rd_sched
// Desc   : Round-robin scheduler for the shared SRAM read port (burst-locked,
//          tagged return steering) and the free-list free port. Optional
//          per-port grant counters when MEM_RD_SCHED_STATS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module mem_rd_sched #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 64,
  parameter int RD_LAT     = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PORTS-1:0]  re_i,
  input  logic [ADDR_W-1:0]     raddr_i [NUM_PORTS],
  output logic [NUM_PORTS-1:0]  gnt_o,
  output logic                  mem_re_o,
  output logic [ADDR_W-1:0]     mem_raddr_o,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [NUM_PORTS-1:0]  rvalid_o,
  output logic [BLOCK_BITS-1:0] rdata_o [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]  free_req_i,
  input  logic [ADDR_W-1:0]     free_block_idx_i [NUM_PORTS],
  output logic [NUM_PORTS-1:0]  free_gnt_o,
  output logic                  free_req_o,
  output logic [ADDR_W-1:0]     free_block_idx_o,
  output logic                  err_o,
  output logic [15:0]           stat_gnt_cnt_o [NUM_PORTS]
);

  localparam int c_ptr_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int c_cnt_w = $clog2(MAX_BURST + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
  localparam logic [0:0] c_s_idle  = 1'b0;
  localparam logic [0:0] c_s_burst = 1'b1;

  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (int'(p) == NUM_PORTS - 1) ? '0 : p + c_ptr_one;
  endfunction

  // Returns {found, index} of the first request at or after start, wrapping.
  function automatic logic [c_ptr_w:0] f_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [c_ptr_w-1:0]   start);
    logic               found;
    logic [c_ptr_w-1:0] idx;
    logic [c_ptr_w-1:0] cur;
    found = 1'b0;
    idx   = '0;
    cur   = start;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[cur]) begin
        found = 1'b1;
        idx   = cur;
      end
      cur = f_inc(cur);
    end
    return {found, idx};
  endfunction

  // ---------------------------------------------------------------- read FSM
  logic [0:0]         r_state, w_state_nxt;
  logic [c_ptr_w-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [c_ptr_w-1:0] r_owner, w_owner_nxt;
  logic [c_cnt_w-1:0] r_burst_cnt, w_cnt_nxt;
  logic               w_hold, w_found, w_gnt_vld;
  logic [c_ptr_w-1:0] w_start, w_win, w_gnt_port;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_s_idle;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // A releasing burst arbitrates from owner+1 in the same cycle (no bubble).
  always_comb begin
    w_hold     = (r_state == c_s_burst) && re_i[r_owner] && (r_burst_cnt < c_max_burst);
    w_start    = (r_state == c_s_burst) ? f_inc(r_owner) : r_rr_ptr;
    {w_found, w_win} = f_pick(re_i, w_start);
    w_gnt_vld  = w_hold || w_found;
    w_gnt_port = w_hold ? r_owner : w_win;
  end

  always_comb begin
    w_state_nxt  = c_s_idle;
    w_rr_ptr_nxt = w_start;
    w_owner_nxt  = r_owner;
    w_cnt_nxt    = '0;
    if (w_hold) begin
      w_state_nxt  = c_s_burst;
      w_rr_ptr_nxt = r_rr_ptr;
      w_cnt_nxt    = r_burst_cnt + c_cnt_one;
    end else if (w_found) begin
      if (MAX_BURST > 1) begin
        w_state_nxt = c_s_burst;
        w_owner_nxt = w_win;
        w_cnt_nxt   = c_cnt_one;
      end else begin
        w_rr_ptr_nxt = f_inc(w_win);
      end
    end
  end

  // Combinational grants are masked by rst_n so every output is 0 in reset.
  always_comb begin
    gnt_o       = '0;
    mem_re_o    = 1'b0;
    mem_raddr_o = '0;
    if (rst_n && w_gnt_vld) begin
      gnt_o[w_gnt_port] = 1'b1;
      mem_re_o          = 1'b1;
      mem_raddr_o       = raddr_i[w_gnt_port];
    end
  end

  // ---------------------------------------------------------------- tag pipe
  logic [RD_LAT-1:0]  r_tag_vld;
  logic [c_ptr_w-1:0] r_tag_port [RD_LAT];
  logic               r_err;
  logic               w_head_vld;
  logic [c_ptr_w-1:0] w_head_port;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag_port[i] <= '0;
    end else begin
      r_tag_vld[0]  <= mem_re_o;
      r_tag_port[0] <= w_gnt_port;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_port[i] <= r_tag_port[i-1];
      end
    end
  end

  assign w_head_vld  = r_tag_vld[RD_LAT-1];
  assign w_head_port = r_tag_port[RD_LAT-1];

  always_comb begin
    rvalid_o = '0;
    if (w_head_vld && mem_rvalid_i) rvalid_o[w_head_port] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_err <= 1'b0;
    else if (w_head_vld != mem_rvalid_i) r_err <= 1'b1;
  end
  assign err_o = r_err;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdata
      assign rdata_o[p] = rst_n ? mem_rdata_i : '0;
    end
  endgenerate

  // ---------------------------------------------------------------- free path
  logic [c_ptr_w-1:0] r_fr_ptr;
  logic               r_free_req;
  logic [ADDR_W-1:0]  r_free_idx;
  logic               w_fr_found;
  logic [c_ptr_w-1:0] w_fr_win;

  always_comb begin
    {w_fr_found, w_fr_win} = f_pick(free_req_i, r_fr_ptr);
    free_gnt_o = '0;
    if (rst_n && w_fr_found) free_gnt_o[w_fr_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fr_ptr   <= '0;
      r_free_req <= 1'b0;
      r_free_idx <= '0;
    end else begin
      r_free_req <= w_fr_found;
      r_free_idx <= w_fr_found ? free_block_idx_i[w_fr_win] : '0;
      if (w_fr_found) r_fr_ptr <= f_inc(w_fr_win);
    end
  end

  assign free_req_o       = r_free_req;
  assign free_block_idx_o = r_free_idx;

  // ---------------------------------------------------------------- stats
`ifdef MEM_RD_SCHED_STATS_EN
  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat
      logic [15:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_cnt <= '0;
        else if (gnt_o[p] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
      assign stat_gnt_cnt_o[p] = r_cnt;
    end
  endgenerate
`else
  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat_off
      assign stat_gnt_cnt_o[p] = '0;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_rd_sched
// Desc   : Scoreboard bench for mem_rd_sched: reference model pushes expected
//          per-cycle outputs and read returns; a negedge monitor pops/compares.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_rd_sched;

  localparam int NP  = 4;
  localparam int AW  = 10;
  localparam int BB  = 64;
  localparam int LAT = 1;
  localparam int MB  = 4;
`ifdef MEM_RD_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] re_i = '0;
  logic [AW-1:0] raddr_i [NP];
  logic [NP-1:0] gnt_o;
  logic          mem_re_o;
  logic [AW-1:0] mem_raddr_o;
  logic          mem_rvalid_i;
  logic [BB-1:0] mem_rdata_i;
  logic [NP-1:0] rvalid_o;
  logic [BB-1:0] rdata_o [NP];
  logic [NP-1:0] free_req_i = '0;
  logic [AW-1:0] free_block_idx_i [NP];
  logic [NP-1:0] free_gnt_o;
  logic          free_req_o;
  logic [AW-1:0] free_block_idx_o;
  logic          err_o;
  logic [15:0]   stat_gnt_cnt_o [NP];

  mem_rd_sched #(.NUM_PORTS(NP), .ADDR_W(AW), .BLOCK_BITS(BB), .RD_LAT(LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .re_i(re_i), .raddr_i(raddr_i), .gnt_o(gnt_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .free_req_i(free_req_i), .free_block_idx_i(free_block_idx_i), .free_gnt_o(free_gnt_o),
    .free_req_o(free_req_o), .free_block_idx_o(free_block_idx_o), .err_o(err_o),
    .stat_gnt_cnt_o(stat_gnt_cnt_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BB-1:0] mdata(input logic [AW-1:0] a);
    return {~a, 20'hC0FFE, a ^ 10'h155, 14'h0, a};
  endfunction

  // SRAM stand-in: returns data for each issued read LAT cycles later.
  logic [LAT-1:0] mp_v;
  logic [AW-1:0]  mp_a [LAT];
  logic           inj = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_v <= '0;
      for (int i = 0; i < LAT; i++) mp_a[i] <= '0;
    end else begin
      mp_v[0] <= mem_re_o;
      mp_a[0] <= mem_raddr_o;
      for (int i = 1; i < LAT; i++) begin
        mp_v[i] <= mp_v[i-1];
        mp_a[i] <= mp_a[i-1];
      end
    end
  end
  assign mem_rvalid_i = mp_v[LAT-1] | inj;
  assign mem_rdata_i  = mdata(mp_a[LAT-1]);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct packed {
    logic [NP-1:0]    gnt;
    logic             re;
    logic [AW-1:0]    addr;
    logic [NP-1:0]    fgnt;
    logic             freq;
    logic [AW-1:0]    fidx;
    logic             err;
    logic [NP*16-1:0] stat;
  } exp_t;
  typedef struct packed {
    int unsigned   due;
    logic [1:0]    port;
    logic [AW-1:0] addr;
  } rd_t;
  exp_t exp_q[$];
  rd_t  rd_q[$];

  // Reference model state: rotation start, current streak, free pointer.
  int            m_ptr, m_sp, m_slen, m_fptr;
  logic          m_freq_d, m_err;
  logic [AW-1:0] m_fidx_d;
  int            m_cnt [NP];
  logic [NP-1:0] m_gnt, m_fgnt;

  function automatic int first_req(input logic [NP-1:0] r, input int start);
    for (int i = 0; i < NP; i++) if (r[(start + i) % NP]) return (start + i) % NP;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sp = 0; m_slen = 0; m_fptr = 0;
    m_freq_d = 1'b0; m_fidx_d = '0; m_err = 1'b0;
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    m_gnt = '0; m_fgnt = '0;
    exp_q.delete();
    rd_q.delete();
  endtask

  task automatic model_cycle();
    exp_t e;
    rd_t  r;
    int   w, f;
    e = '0;
    if (m_slen > 0 && re_i[m_sp] && m_slen < MB) begin
      w = m_sp;
      m_slen++;
    end else begin
      if (m_slen > 0) begin
        m_ptr  = (m_sp + 1) % NP;
        m_slen = 0;
      end
      w = first_req(re_i, m_ptr);
      if (w >= 0) begin
        if (MB > 1) begin m_sp = w; m_slen = 1; end
        else m_ptr = (w + 1) % NP;
      end
    end
    m_gnt = '0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      e.re     = 1'b1;
      e.addr   = raddr_i[w];
      r.due    = cyc + LAT;
      r.port   = 2'(w);
      r.addr   = raddr_i[w];
      rd_q.push_back(r);
    end
    e.gnt  = m_gnt;
    e.freq = m_freq_d;
    e.fidx = m_fidx_d;
    e.err  = m_err;
    for (int p = 0; p < NP; p++)
      e.stat[p*16 +: 16] = STATS ? 16'((m_cnt[p] > 65535) ? 65535 : m_cnt[p]) : 16'h0;
    if (w >= 0) m_cnt[w]++;
    f = first_req(free_req_i, m_fptr);
    m_fgnt   = '0;
    m_freq_d = (f >= 0);
    m_fidx_d = '0;
    if (f >= 0) begin
      m_fgnt[f] = 1'b1;
      m_fidx_d  = free_block_idx_i[f];
      m_fptr    = (f + 1) % NP;
    end
    e.fgnt = m_fgnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    model_cycle();
    tick();
  endtask

  logic mon_en = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t          e;
    rd_t           r;
    logic [NP-1:0] oh;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_underrun at cycle %0d: got empty queue, expected an entry", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("gnt_o", 64'(gnt_o), 64'(e.gnt));
        chk("mem_re_o", 64'(mem_re_o), 64'(e.re));
        chk("mem_raddr_o", 64'(mem_raddr_o), 64'(e.addr));
        chk("free_gnt_o", 64'(free_gnt_o), 64'(e.fgnt));
        chk("free_req_o", 64'(free_req_o), 64'(e.freq));
        chk("free_block_idx_o", 64'(free_block_idx_o), 64'(e.fidx));
        chk("err_o", 64'(err_o), 64'(e.err));
        for (int p = 0; p < NP; p++)
          chk("stat_gnt_cnt_o", 64'(stat_gnt_cnt_o[p]), 64'(e.stat[p*16 +: 16]));
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        r  = rd_q.pop_front();
        oh = '0;
        oh[r.port] = 1'b1;
        chk("rvalid_o", 64'(rvalid_o), 64'(oh));
        for (int p = 0; p < NP; p++) chk("rdata_o", rdata_o[p], mdata(r.addr));
      end else begin
        chk("rvalid_o_idle", 64'(rvalid_o), 64'h0);
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_gnt_o", 64'(gnt_o), 64'h0);
    chk("rst_mem_re_o", 64'(mem_re_o), 64'h0);
    chk("rst_mem_raddr_o", 64'(mem_raddr_o), 64'h0);
    chk("rst_rvalid_o", 64'(rvalid_o), 64'h0);
    chk("rst_free_gnt_o", 64'(free_gnt_o), 64'h0);
    chk("rst_free_req_o", 64'(free_req_o), 64'h0);
    chk("rst_free_block_idx_o", 64'(free_block_idx_o), 64'h0);
    chk("rst_err_o", 64'(err_o), 64'h0);
    for (int p = 0; p < NP; p++) begin
      chk("rst_stat", 64'(stat_gnt_cnt_o[p]), 64'h0);
      chk("rst_rdata_o", rdata_o[p], 64'h0);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n1;
    for (int p = 0; p < NP; p++) begin
      raddr_i[p] = '0;
      free_block_idx_i[p] = '0;
    end
    // Reset with requests pending: everything must stay quiet.
    re_i = 4'b0101;
    free_req_i = 4'b1010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    tick();
    re_i = '0;
    free_req_i = '0;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Single requester streaming 0x10..0x15 across a burst boundary.
    re_i = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      raddr_i[2] = AW'(16 + k);
      step();
    end
    re_i = '0;
    repeat (2) step();

    // All ports saturating: 4-deep bursts in rotation.
    re_i = '1;
    for (int k = 0; k < 20; k++) begin
      for (int p = 0; p < NP; p++) raddr_i[p] = AW'($urandom);
      step();
    end
    re_i = '0;
    repeat (2) step();

    // Port 1 drops after two grants while port 3 waits.
    re_i = 4'b1010;
    raddr_i[1] = 10'h031;
    raddr_i[3] = 10'h033;
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (m_gnt[1]) n1++;
      if (n1 == 2) re_i[1] = 1'b0;
    end
    re_i = '0;
    repeat (2) step();

    // Simultaneous frees from ports 0 and 3.
    free_req_i = 4'b1001;
    free_block_idx_i[0] = 10'h005;
    free_block_idx_i[3] = 10'h02A;
    for (int k = 0; k < 3; k++) begin
      step();
      free_req_i = free_req_i & ~m_fgnt;
    end
    free_req_i = '0;
    repeat (LAT + 2) step();

    // Spurious read-data valid with nothing in flight.
    inj = 1'b1;
    step();
    inj = 1'b0;
    m_err = 1'b1;
    repeat (3) step();

    // Reset mid-burst.
    re_i = 4'b0001;
    raddr_i[0] = 10'h0AA;
    repeat (2) step();
    mon_en = 1'b0;
    rst_n = 1'b0;
    free_req_i = 4'b0010;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    tick();
    model_reset();
    re_i = '0;
    free_req_i = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) step();

    // Random traffic; requesters hold until granted.
    for (int k = 0; k < 1500; k++) begin
      for (int p = 0; p < NP; p++) begin
        if (!re_i[p] || m_gnt[p]) begin
          re_i[p]    = ($urandom_range(0, 99) < 60);
          raddr_i[p] = AW'($urandom);
        end
        if (!free_req_i[p] || m_fgnt[p]) begin
          free_req_i[p]       = ($urandom_range(0, 99) < 40);
          free_block_idx_i[p] = AW'($urandom);
        end
      end
      step();
    end

`ifdef MEM_RD_SCHED_STATS_EN
    // Saturation of port 0 counter.
    re_i = 4'b0001;
    free_req_i = '0;
    for (int k = 0; k < 70000; k++) begin
      raddr_i[0] = AW'(k);
      step();
    end
`endif

    re_i = '0;
    free_req_i = '0;
    repeat (LAT + 3) step();
    mon_en = 1'b0;
    @(negedge clk);
`ifdef MEM_RD_SCHED_STATS_EN
    chk("stat_saturated", 64'(stat_gnt_cnt_o[0]), 64'hFFFF);
`else
    chk("stat_tied_off", 64'(stat_gnt_cnt_o[0]), 64'h0);
`endif
    chk("read_returns_drained", 64'(rd_q.size()), 64'h0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
